la_pwrseq: RTL



---
 rtl/la_pwrseq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/la_pwrseq.sv
// Power-domain switch sequencer: staggers N segment enables, orders retention and
// isolation around the ramp, acks on a level handshake. LA_PWRSEQ_RET_EN enables retention steps.
module la_pwrseq #(
  parameter int    N    = 4,
  parameter int    STEP = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  output logic         ack,
  output logic [N-1:0] pwr_en,
  output logic         iso,
  output logic         ret,
  output logic         busy
);

  localparam int CW = $clog2(STEP + 1);

  typedef enum logic [2:0] {
    S_OFF, S_UP, S_WRET, S_WISO, S_ON, S_SAVE, S_DOWN
  } state_t;

`ifdef LA_PWRSEQ_RET_EN
  localparam state_t S_RAMPED  = S_WRET;
  localparam state_t S_RELEASE = S_SAVE;
  localparam logic   RET_RST   = 1'b1;
`else
  localparam state_t S_RAMPED  = S_WISO;
  localparam state_t S_RELEASE = S_DOWN;
  localparam logic   RET_RST   = 1'b0;
`endif

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [N-1:0]   r_pwr, w_pwr_nxt;
  logic           r_iso, w_iso_nxt;
  logic           r_ret, w_ret_nxt;
  logic           r_ack, w_ack_nxt;
  logic           r_busy, w_busy_nxt;
  logic           w_evt;
  logic [N-1:0]   w_shl;
  logic [N-1:0]   w_shr;

  assign w_evt = (r_cnt == CW'(STEP - 1));
  assign w_shl = (r_pwr << 1) | N'(1);
  assign w_shr = r_pwr >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_pwr   <= '0;
      r_iso   <= 1'b1;
      r_ret   <= RET_RST;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pwr   <= w_pwr_nxt;
      r_iso   <= w_iso_nxt;
      r_ret   <= w_ret_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Abort requests take priority over a coincident sequencing event.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF:  if (req) w_state_nxt = (w_shl == '1) ? S_RAMPED : S_UP;
      S_UP: begin
        if (!req)      w_state_nxt = S_DOWN;
        else if (w_evt) w_state_nxt = (w_shl == '1) ? S_RAMPED : S_UP;
      end
      S_WRET: begin
        if (!req)      w_state_nxt = S_DOWN;
        else if (w_evt) w_state_nxt = S_WISO;
      end
      S_WISO: begin
        if (!req)      w_state_nxt = S_RELEASE;
        else if (w_evt) w_state_nxt = S_ON;
      end
      S_ON:   if (!req) w_state_nxt = S_RELEASE;
      S_SAVE: if (w_evt) w_state_nxt = S_DOWN;
      S_DOWN: begin
        if (req)                         w_state_nxt = S_UP;
        else if (w_evt && (w_shr == '0)) w_state_nxt = S_OFF;
      end
      default: w_state_nxt = S_OFF;
    endcase
    w_cnt_nxt = ((w_state_nxt != r_state) || w_evt) ? '0 : r_cnt + CW'(1);
  end

  always_comb begin
    w_pwr_nxt  = r_pwr;
    w_iso_nxt  = r_iso;
    w_ret_nxt  = r_ret;
    w_ack_nxt  = r_ack;
    case (r_state)
      S_OFF:  if (req) w_pwr_nxt = w_shl;
      S_UP:   if (req && w_evt) w_pwr_nxt = w_shl;
      S_WRET: if (req && w_evt) w_ret_nxt = 1'b0;
      S_WISO: begin
        if (req && w_evt) begin
          w_iso_nxt = 1'b0;
          w_ack_nxt = 1'b1;
        end
      end
      S_ON: begin
        if (!req) begin
          w_iso_nxt = 1'b1;
          w_ack_nxt = 1'b0;
        end
      end
      S_SAVE: if (w_evt) w_ret_nxt = 1'b1;
      S_DOWN: if (!req && w_evt) w_pwr_nxt = w_shr;
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt != S_OFF) && (w_state_nxt != S_ON);
  end

  assign pwr_en = r_pwr;
  assign iso    = r_iso;
  assign ret    = r_ret;
  assign ack    = r_ack;
  assign busy   = r_busy;

endmodule
